// File: rtl/ahb_ifetch_pkg.sv
// Shared AHB-Lite encodings, fetch FSM state type and the instruction-buffer entry layout.
// Pure declarations; no logic, no latency.
package ahb_ifetch_pkg;

  localparam logic [1:0] HTRANS_IDLE       = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ     = 2'b10;
  localparam logic [2:0] HSIZE_WORD        = 3'b010;
  localparam logic [2:0] HBURST_SINGLE     = 3'b000;
  localparam logic [3:0] HPROT_OPCODE_PRIV = 4'b0010;
  localparam logic       HRESP_OKAY        = 1'b0;
  localparam logic       HRESP_ERROR       = 1'b1;

  typedef enum logic {
    FETCH = 1'b0,
    HALT  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] pc;
    logic        err;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous instruction buffer with flush; head visible the cycle after push, zero when empty.
// No internal backpressure: the fetcher only issues when a slot is guaranteed.
module ifetch_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     not_empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign not_empty = (count != '0);
  // Empty head reads as zero so the consumer-side outputs are clean after reset/flush.
  assign head      = not_empty ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ahb_ifetch.sv
// AHB-Lite instruction fetcher: pipelined single-word reads into a small buffer, first word 2 cycles after reset.
// Issues only while buffer slots remain (counting the outstanding beat); halts on ERROR until redirected.
module ahb_ifetch import ahb_ifetch_pkg::*; #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        HCLK,
  input  logic        HRESET,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  output logic        instr_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t state, state_nxt;
  logic [31:0]  fetch_pc;
  logic         hold_vld, hold_disc;
  logic [31:0]  hold_addr;
  logic         dp_vld, dp_disc;
  logic [31:0]  dp_addr;
  logic [CW-1:0] fifo_count;
  logic [CW:0]  occupancy;
  logic         issue, addr_act, addr_done, dp_done, push, pop, err_push;
  fetch_entry_t entry, head;

  assign HWRITE = 1'b0;
  assign HSIZE  = HSIZE_WORD;
  assign HBURST = HBURST_SINGLE;
  assign HPROT  = HPROT_OPCODE_PRIV;

  // Slots in use once this cycle's pop retires: a pop frees room for a new address in the same cycle.
  assign pop       = instr_valid && instr_ready;
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(dp_vld) - (CW+1)'(pop);
  assign issue     = (state == FETCH) && (occupancy < (CW+1)'(FIFO_DEPTH));

  // A held address phase must stay on the bus until HREADY, whatever happened to fetch_pc meanwhile.
  assign addr_act  = !HRESET && (hold_vld || issue);
  assign HTRANS    = addr_act ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign HADDR     = hold_vld ? hold_addr : fetch_pc;
  assign addr_done = addr_act && HREADY;

  assign dp_done   = dp_vld && HREADY;
  assign push      = dp_done && !dp_disc && !redirect_valid;
  assign err_push  = push && (HRESP == HRESP_ERROR);
  assign entry     = '{data: HRDATA, pc: dp_addr, err: HRESP};

  always_comb begin
    state_nxt = state;
    if (redirect_valid)  state_nxt = FETCH;
    else if (err_push)   state_nxt = HALT;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) state <= FETCH;
    else        state <= state_nxt;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      fetch_pc  <= RESET_PC;
      hold_vld  <= 1'b0;
      hold_disc <= 1'b0;
      hold_addr <= '0;
      dp_vld    <= 1'b0;
      dp_disc   <= 1'b0;
      dp_addr   <= '0;
    end else begin
      if (redirect_valid)              fetch_pc <= word_align(redirect_pc);
      else if (addr_done && !hold_disc) fetch_pc <= fetch_pc + 32'd4;

      if (HREADY) begin
        hold_vld  <= 1'b0;
        hold_disc <= 1'b0;
      end else begin
        hold_vld  <= addr_act;
        hold_addr <= HADDR;
        hold_disc <= hold_disc || (redirect_valid && addr_act);
      end

      // The beat issued alongside an ERROR response belongs to the abandoned stream.
      if (HREADY) begin
        dp_vld  <= addr_act;
        dp_addr <= HADDR;
        dp_disc <= redirect_valid || hold_disc || err_push;
      end else begin
        dp_disc <= dp_disc || redirect_valid;
      end
    end
  end

  ifetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (HCLK),
    .rst       (HRESET),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (entry),
    .pop       (pop),
    .head      (head),
    .not_empty (instr_valid),
    .count     (fifo_count)
  );

  assign instr_data = head.data;
  assign instr_pc   = head.pc;
  assign instr_err  = head.err;

endmodule

// File: tb/tb_ahb_ifetch.sv
// Bench for ahb_ifetch: directed scenarios plus random bus/consumer traffic against an
// expected-instruction-stream model (pc sequence, ROM contents, error map).
module tb_ahb_ifetch;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [1:0]  T_IDLE = 2'b00;
  localparam logic [1:0]  T_NSEQ = 2'b10;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_err;

  always #5 HCLK = ~HCLK;

  ahb_ifetch #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_data(instr_data),
    .instr_pc(instr_pc), .instr_err(instr_err)
  );

  int n_chk = 0;
  int n_err = 0;

  int          err_mode;
  logic [31:0] err_addr;

  // Sampled per cycle at the falling edge.
  logic [1:0]  s_trans;
  logic [31:0] s_addr, s_ipc, s_idata, s_rpc;
  logic        s_ivld, s_ierr, s_hready, s_rdy, s_redir, s_rst;

  logic        sl_vld;
  logic [31:0] sl_addr;

  logic [31:0] exp_pc;
  logic        exp_halted;
  int          n_acc;
  logic        prev_stall;
  logic [31:0] prev_addr;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return ((a >> 2) + 32'd1) * 32'd17;
  endfunction

  function automatic logic err_of(input logic [31:0] a);
    if (err_mode == 1) return a == err_addr;
    if (err_mode == 2) return a[7:2] == 6'h2A;
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge HCLK);
    s_trans = HTRANS;  s_addr = HADDR;   s_ivld = instr_valid; s_ipc = instr_pc;
    s_idata = instr_data; s_ierr = instr_err; s_hready = HREADY; s_rdy = instr_ready;
    s_redir = redirect_valid; s_rpc = redirect_pc; s_rst = HRESET;
    if (s_rst) begin
      prev_stall = 1'b0;
      exp_pc     = RST_PC;
      exp_halted = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_htrans", s_trans, T_NSEQ);
        chk("stall_haddr", s_addr, prev_addr);
      end
      prev_stall = (s_trans == T_NSEQ) && !s_hready;
      prev_addr  = s_addr;
      if (exp_halted) begin
        chk("halt_idle", s_trans, T_IDLE);
        chk("halt_empty", s_ivld, 1'b0);
      end else if (s_ivld && s_rdy && !s_redir) begin
        n_acc++;
        chk("instr_pc", s_ipc, exp_pc);
        chk("instr_data", s_idata, rom(exp_pc));
        chk("instr_err", s_ierr, err_of(exp_pc));
        if (err_of(exp_pc)) exp_halted = 1'b1;
        exp_pc = exp_pc + 32'd4;
      end
      if (s_redir) begin
        exp_pc     = {s_rpc[31:2], 2'b00};
        exp_halted = 1'b0;
      end
    end
    @(posedge HCLK);
    #1;
    if (s_rst) sl_vld = 1'b0;
    else if (s_hready) begin
      sl_vld  = (s_trans == T_NSEQ);
      sl_addr = s_addr;
    end
    HRDATA = sl_vld ? rom(sl_addr) : $urandom;
    HRESP  = sl_vld && err_of(sl_addr);
  endtask

  task automatic next_issue(input string tag, input logic [31:0] exp);
    bit found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (s_trans == T_NSEQ) found = 1;
    end
    chk({tag, "_htrans"}, s_trans, T_NSEQ);
    if (found) chk(tag, s_addr, exp);
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] exp);
    bit found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (s_ivld) found = 1;
    end
    chk({tag, "_vld"}, s_ivld, 1'b1);
    if (found) chk(tag, s_ipc, exp);
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int nonseq, acc0;
    bit found;
    logic [31:0] held;

    HRESET = 1'b1; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    err_mode = 0; err_addr = '0; sl_vld = 1'b0; sl_addr = '0;
    exp_pc = RST_PC; exp_halted = 1'b0; n_acc = 0; prev_stall = 1'b0; prev_addr = '0;

    step(); step();
    chk("rst_htrans", s_trans, T_IDLE);
    chk("rst_ivld", s_ivld, 1'b0);
    chk("rst_idata", s_idata, 32'h0);
    chk("rst_ipc", s_ipc, 32'h0);
    chk("rst_ierr", s_ierr, 1'b0);
    chk("hwrite", HWRITE, 1'b0);
    chk("hsize", HSIZE, 3'b010);
    chk("hburst", HBURST, 3'b000);
    chk("hprot", HPROT, 4'b0010);

    // Reset release, zero-bubble stream from 0x0.
    HRESET = 1'b0; instr_ready = 1'b1;
    step();
    chk("t1_c0_htrans", s_trans, T_NSEQ);
    chk("t1_c0_haddr", s_addr, 32'h0);
    chk("t1_c0_ivld", s_ivld, 1'b0);
    step();
    chk("t1_c1_ivld", s_ivld, 1'b0);
    chk("t1_c1_haddr", s_addr, 32'h4);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t1_ivld", s_ivld, 1'b1);
      chk("t1_pc", s_ipc, 32'(4 * i));
      chk("t1_data", s_idata, 32'(17 * (i + 1)));
    end

    // Consumer stalled: exactly DEPTH fetches, then idle; resume at full rate.
    instr_ready = 1'b0;
    redirect(32'h0000_0200);
    nonseq = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (s_trans == T_NSEQ && s_hready) nonseq++;
    end
    chk("t2_issued", nonseq, DEPTH);
    chk("t2_idle", s_trans, T_IDLE);
    chk("t2_head_vld", s_ivld, 1'b1);
    chk("t2_head_pc", s_ipc, 32'h200);
    instr_ready = 1'b1;
    acc0 = n_acc;
    for (int i = 0; i < 8; i++) step();
    chk("t2_resume_words", n_acc - acc0, 8);

    // Redirect with a data phase outstanding.
    redirect(32'h0000_0103);
    next_issue("t3_haddr", 32'h100);
    wait_valid("t3_pc", 32'h100);

    // ERROR response at 0x8 halts fetch until redirect.
    err_mode = 1; err_addr = 32'h8;
    redirect(32'h0);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (s_ivld && s_ierr) found = 1;
    end
    chk("t4_err", s_ierr, 1'b1);
    chk("t4_err_pc", s_ipc, 32'h8);
    nonseq = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (s_trans == T_NSEQ) nonseq++;
    end
    chk("t4_halt_issue", nonseq, 0);
    chk("t4_halt_vld", s_ivld, 1'b0);
    err_mode = 0;
    redirect(32'h0);
    next_issue("t4_resume", 32'h0);

    // Redirect in the middle of a 3-cycle HREADY stall.
    step(); step(); step();
    HREADY = 1'b0;
    step();
    chk("t5_s1_htrans", s_trans, T_NSEQ);
    held = s_addr;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    step();
    redirect_valid = 1'b0;
    chk("t5_s2_haddr", s_addr, held);
    step();
    chk("t5_s3_haddr", s_addr, held);
    HREADY = 1'b1;
    step();
    chk("t5_s4_haddr", s_addr, held);
    step();
    chk("t5_new_htrans", s_trans, T_NSEQ);
    chk("t5_new_haddr", s_addr, 32'h300);
    wait_valid("t5_pc", 32'h300);

    // Address wrap at the top of the space.
    redirect(32'hFFFF_FFFC);
    next_issue("t6_addr0", 32'hFFFF_FFFC);
    step();
    chk("t6_addr1", s_addr, 32'h0);
    wait_valid("t6_pc0", 32'hFFFF_FFFC);
    step();
    chk("t6_pc1_vld", s_ivld, 1'b1);
    chk("t6_pc1", s_ipc, 32'h0);

    // Random traffic with periodic errors, redirects and one mid-stream reset.
    err_mode = 2;
    redirect(32'h0);
    acc0 = n_acc;
    for (int c = 0; c < 2000; c++) begin
      HREADY         = !sl_vld || ($urandom_range(0, 3) != 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      HRESET         = (c == 1000 || c == 1001);
      redirect_valid = !HRESET && ($urandom_range(0, 39) == 0);
      redirect_pc    = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FF00 | 32'($urandom_range(0, 255)))
                                                  : 32'($urandom_range(0, 4095));
      step();
      if (c == 1001) chk("rand_rst_htrans", s_trans, T_IDLE);
    end
    HRESET = 1'b0; redirect_valid = 1'b0;
    chk("rand_progress", (n_acc - acc0) > 200, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ahb_ifetch.md
AHB_IFETCH -- requirements
Module: ahb_ifetch

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter: FIFO_DEPTH, 2, instruction buffer entries (power of two, 2..8).
REQ-003 Port: HCLK  in  1  system clock; all logic is on its rising edge.
REQ-004 Port: HRESET  in  1  reset, synchronous, active-high.
REQ-005 Port: HADDR  out  32  fetch address, word aligned.
REQ-006 Port: HTRANS  out  2  IDLE=2'b00 or NONSEQ=2'b10 only.
REQ-007 Port: HWRITE  out  1  constant 0.
REQ-008 Port: HSIZE  out  3  constant 3'b010 (word).
REQ-009 Port: HBURST  out  3  constant 3'b000 (SINGLE).
REQ-010 Port: HPROT  out  4  constant 4'b0010 (opcode fetch, privileged).
REQ-011 Port: HRDATA  in  32  read data.
REQ-012 Port: HREADY  in  1  transfer done / bus advance.
REQ-013 Port: HRESP  in  1  0=OKAY, 1=ERROR.
REQ-014 Port: redirect_valid  in  1  one-cycle request to restart fetch.
REQ-015 Port: redirect_pc  in  32  new fetch address; bits [1:0] ignored.
REQ-016 Port: instr_valid  out  1  FIFO head valid.
REQ-017 Port: instr_ready  in  1  consumer accepts head.
REQ-018 Port: instr_data  out  32  FIFO head instruction word.
REQ-019 Port: instr_pc  out  32  FIFO head address.
REQ-020 Port: instr_err  out  1  FIFO head carries bus ERROR.

Function
REQ-021 AHB-Lite pipeline: address phase in cycle N, data phase from the first cycle with HREADY=1 after it; at most one data phase outstanding.
REQ-022 Issue NONSEQ only when state=FETCH and (fifo_count + outstanding) < FIFO_DEPTH; otherwise HTRANS=IDLE.
REQ-023 HADDR/HTRANS held stable while HREADY=0; address phase completes on HREADY=1.
REQ-024 After each completed address phase, fetch_pc += 4, wrapping modulo 2^32.
REQ-025 Data phase completing with HREADY=1 pushes {HRDATA, addr, HRESP} into the FIFO unless marked discard.
REQ-026 Pop occurs when instr_valid && instr_ready; push and pop in same cycle leave count unchanged.
REQ-027 Zero-bubble throughput: with HREADY=1 and instr_ready=1, one instruction per cycle after 2-cycle initial latency (reset release to first instr_valid).
REQ-028 States: FETCH, HALT; reset enters FETCH.
REQ-029 FETCH -> HALT when an ERROR entry is pushed; no further issue in HALT.
REQ-030 HALT -> FETCH only on redirect_valid.
REQ-031 redirect_valid: flush FIFO, mark any outstanding data phase discard, fetch_pc <= {redirect_pc[31:2],2'b00}; redirect wins over simultaneous push and pop.
REQ-032 redirect_valid while an address phase is stalled (HREADY=0): the stalled transfer completes unchanged and is discarded; new address issued on the cycle after it completes.
REQ-033 A second redirect before the first takes effect overrides it (last wins).
REQ-034 FIFO full: no issue; data already outstanding always has a free slot (guaranteed by REQ-022).

Reset
REQ-035 On HRESET=1 at a rising edge: fetch_pc=RESET_PC, state=FETCH, FIFO empty, outstanding=0, HTRANS=IDLE, instr_valid=0, instr_data=0, instr_pc=0, instr_err=0.
REQ-036 Reset mid-transfer abandons the outstanding data phase; its response is ignored.

Structure
REQ-037 Shared package holds HTRANS/HSIZE/HBURST/HRESP encodings and the FETCH/HALT state type.
REQ-038 One sub-module: ifetch_fifo (synchronous FIFO, width 65, depth FIFO_DEPTH, flush input).

Verification
REQ-039 Reset release, ROM returns 0x11,0x22,0x33 at 0x0,0x4,0x8, instr_ready=1 -> instr_pc 0x0,0x4,0x8 on consecutive cycles, first instr_valid 2 cycles after reset release.
REQ-040 instr_ready=0 for 10 cycles -> exactly FIFO_DEPTH transfers issued, then HTRANS=IDLE; resume yields no lost or duplicated words.
REQ-041 redirect_pc=0x0000_0103 while a data phase is outstanding -> that word dropped, next HADDR=0x0000_0100, next instr_pc=0x100.
REQ-042 HRESP=1 at 0x0000_0008 -> entry with instr_err=1, instr_pc=0x8; HTRANS=IDLE until redirect to 0x0 resumes fetch.
REQ-043 HREADY=0 for 3 cycles with redirect_valid mid-stall -> HADDR stable during stall, stalled word discarded, redirect address issued next.
REQ-044 redirect_pc=0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000.
